game_flow_fsm: RTL and testbench

Parametrised next-generation in-game sequencer for the Tetris core. It owns piece spawn, gravity timing, soft drop, lock delay with a bounded move-reset budget and an optional step reset, line-clear and garbage handshakes, entry delay (ARE) and top-out detection. It sits between the input/movement logic and the playfield/garbage units and replaces the single-cycle lock/garbage sequencing with parametrised, handshaked phases.

---
 rtl/game_flow_fsm.sv | 224 ++++++++++++++++++++++
 tb/tb_game_flow_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_fsm.sv
// game_flow_fsm
// In-game sequencer for the Tetris core. It decides when a piece spawns,
// when gravity moves it, when it locks (lock delay with a bounded budget of
// move-resets and an optional step reset), and it walks the line-clear,
// garbage and entry-delay phases before the next spawn. A blocked spawn
// ends the game in TOP_OUT.
//
// Ports:
//   clk, rst_l          clock, asynchronous active-low reset
//   game_start          start request, honoured in IDLE and TOP_OUT
//   game_end            abort to IDLE, overrides every other transition
//   user_input          a move/rotate succeeded this cycle
//   hard_drop           hard-drop request
//   soft_drop           soft drop held (shortens the gravity period)
//   falling_row/col     position of the falling piece (row grows downward)
//   ghost_row/col       position of the ghost piece
//   lines_pending       the locked piece completed at least one line
//   clear_done          playfield finished clearing
//   garbage_pending     garbage rows are queued
//   garbage_done        garbage unit finished
//   spawn_blocked       spawn location is occupied
//   new_tetromino       one-cycle spawn pulse
//   gravity_tick        move the piece down one row (combinational)
//   falling_piece_lock  one-cycle lock pulse
//   line_clear          clear request level
//   load_garbage        garbage request level
//   top_out             game-over level
//   lock_resets_used    move-resets consumed by the current piece
//   state_dbg           current FSM state encoding
//
// Handshakes: line_clear and load_garbage are request levels that stay high
// for as long as the FSM sits in the matching state; the partner raises
// clear_done / garbage_done for one or more cycles and the FSM leaves on the
// clock edge that follows the first cycle where done is seen high.

module game_flow_fsm #(
    parameter int COORD_W          = 5,
    parameter int CTR_W            = 32,
    parameter int LOCK_DELAY       = 15,
    parameter int MAX_LOCK_RESETS  = 15,
    parameter int GRAVITY_PERIOD   = 60,
    parameter int SOFT_DROP_PERIOD = 3,
    parameter int ENTRY_DELAY      = 0,
    parameter int STEP_RESET_EN    = 1,
    parameter int RST_W            = $clog2(MAX_LOCK_RESETS + 1)
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               game_start,
    input  logic               game_end,
    input  logic               user_input,
    input  logic               hard_drop,
    input  logic               soft_drop,
    input  logic [COORD_W-1:0] falling_row,
    input  logic [COORD_W-1:0] falling_col,
    input  logic [COORD_W-1:0] ghost_row,
    input  logic [COORD_W-1:0] ghost_col,
    input  logic               lines_pending,
    input  logic               clear_done,
    input  logic               garbage_pending,
    input  logic               garbage_done,
    input  logic               spawn_blocked,
    output logic               new_tetromino,
    output logic               gravity_tick,
    output logic               falling_piece_lock,
    output logic               line_clear,
    output logic               load_garbage,
    output logic               top_out,
    output logic [RST_W-1:0]   lock_resets_used,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_NEW_PIECE    = 3'd1,
        S_PIECE_FALL   = 3'd2,
        S_PIECE_LOCK   = 3'd3,
        S_LINE_CLEAR   = 3'd4,
        S_LOAD_GARBAGE = 3'd5,
        S_ENTRY        = 3'd6,
        S_TOP_OUT      = 3'd7
    } state_t;

    localparam logic [CTR_W-1:0] CTR_ONE    = CTR_W'(1);
    localparam logic [CTR_W-1:0] LOCK_LOAD  = CTR_W'(LOCK_DELAY);
    localparam logic [CTR_W-1:0] GRAV_LAST  = CTR_W'(GRAVITY_PERIOD - 1);
    localparam logic [CTR_W-1:0] SOFT_LAST  = CTR_W'(SOFT_DROP_PERIOD - 1);
    // ENTRY always lasts at least one cycle; with a delay of d it lasts d.
    localparam logic [CTR_W-1:0] ENTRY_LAST = (ENTRY_DELAY == 0) ? '0 : CTR_W'(ENTRY_DELAY - 1);
    localparam logic [RST_W-1:0] RST_ONE    = RST_W'(1);
    localparam logic [RST_W-1:0] MAX_RST    = RST_W'(MAX_LOCK_RESETS);

    state_t             state, state_n;
    logic [CTR_W-1:0]   lock_ctr, lock_n;
    logic [CTR_W-1:0]   grav_ctr, grav_n;
    logic [CTR_W-1:0]   entry_ctr, entry_n;
    logic [RST_W-1:0]   reset_cnt, rcnt_n;
    logic [COORD_W-1:0] lowest_row, low_n;
    logic               grounded;

    assign grounded = (state == S_PIECE_FALL) &&
                      (falling_row == ghost_row) && (falling_col == ghost_col);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= S_IDLE;
            lock_ctr   <= '0;
            grav_ctr   <= '0;
            entry_ctr  <= '0;
            reset_cnt  <= '0;
            lowest_row <= '0;
        end else begin
            state      <= state_n;
            lock_ctr   <= lock_n;
            grav_ctr   <= grav_n;
            entry_ctr  <= entry_n;
            reset_cnt  <= rcnt_n;
            lowest_row <= low_n;
        end
    end

    always_comb begin
        state_n      = state;
        lock_n       = lock_ctr;
        grav_n       = grav_ctr;
        entry_n      = entry_ctr;
        rcnt_n       = reset_cnt;
        low_n        = lowest_row;
        gravity_tick = 1'b0;

        case (state)
            S_IDLE: begin
                if (game_start) state_n = S_NEW_PIECE;
            end

            S_NEW_PIECE: begin
                lock_n  = LOCK_LOAD;
                grav_n  = GRAV_LAST;
                rcnt_n  = '0;
                low_n   = '0;
                state_n = spawn_blocked ? S_TOP_OUT : S_PIECE_FALL;
            end

            S_PIECE_FALL: begin
                if (hard_drop) begin
                    // Hard drop freezes every counter: no tick, no reload.
                    state_n = S_PIECE_LOCK;
                end else begin
                    if (grounded && (lock_ctr == '0)) begin
                        state_n = S_PIECE_LOCK;
                    end else if ((STEP_RESET_EN != 0) && (falling_row > lowest_row)) begin
                        // New lowest row: a fresh lock budget for this depth.
                        low_n  = falling_row;
                        lock_n = LOCK_LOAD;
                        rcnt_n = '0;
                    end else if (grounded && user_input && (reset_cnt < MAX_RST)) begin
                        lock_n = LOCK_LOAD;
                        rcnt_n = reset_cnt + RST_ONE;
                    end else if (grounded) begin
                        lock_n = lock_ctr - CTR_ONE;
                    end

                    if (!grounded) begin
                        // Pressing soft drop with a long way to go replaces the
                        // countdown with the short period instead of ticking.
                        if (soft_drop && (grav_ctr > SOFT_LAST)) begin
                            grav_n = SOFT_LAST;
                        end else if (grav_ctr == '0) begin
                            gravity_tick = 1'b1;
                            grav_n       = soft_drop ? SOFT_LAST : GRAV_LAST;
                        end else begin
                            grav_n = grav_ctr - CTR_ONE;
                        end
                    end
                end
            end

            S_PIECE_LOCK: begin
                if (lines_pending)        state_n = S_LINE_CLEAR;
                else if (garbage_pending) state_n = S_LOAD_GARBAGE;
                else                      state_n = S_ENTRY;
            end

            S_LINE_CLEAR: begin
                if (clear_done) state_n = garbage_pending ? S_LOAD_GARBAGE : S_ENTRY;
            end

            S_LOAD_GARBAGE: begin
                if (garbage_done) state_n = S_ENTRY;
            end

            S_ENTRY: begin
                if (entry_ctr >= ENTRY_LAST) begin
                    entry_n = '0;
                    state_n = S_NEW_PIECE;
                end else begin
                    entry_n = entry_ctr + CTR_ONE;
                end
            end

            S_TOP_OUT: begin
                if (game_start) state_n = S_NEW_PIECE;
            end

            default: state_n = S_IDLE;
        endcase

        // Abort wins over everything; clearing the count keeps IDLE outputs at 0.
        if (game_end) begin
            state_n = S_IDLE;
            rcnt_n  = '0;
            entry_n = '0;
        end
    end

    assign new_tetromino      = (state == S_NEW_PIECE);
    assign falling_piece_lock = (state == S_PIECE_LOCK);
    assign line_clear         = (state == S_LINE_CLEAR);
    assign load_garbage       = (state == S_LOAD_GARBAGE);
    assign top_out            = (state == S_TOP_OUT);
    assign lock_resets_used   = reset_cnt;
    assign state_dbg          = state;

endmodule

// File: tb/tb_game_flow_fsm.sv
// Bench for game_flow_fsm: a table of per-cycle input/expected-output records
// applied in a loop through an expected-value queue, plus hand-written
// sequences for reset behaviour.

module tb_game_flow_fsm;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       game_start, game_end, user_input, hard_drop, soft_drop;
    logic [4:0] falling_row, falling_col, ghost_row, ghost_col;
    logic       lines_pending, clear_done, garbage_pending, garbage_done, spawn_blocked;
    logic       new_tetromino, gravity_tick, falling_piece_lock;
    logic       line_clear, load_garbage, top_out;
    logic [1:0] lock_resets_used;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    game_flow_fsm #(
        .COORD_W(5), .CTR_W(32), .LOCK_DELAY(4), .MAX_LOCK_RESETS(2),
        .GRAVITY_PERIOD(8), .SOFT_DROP_PERIOD(2), .ENTRY_DELAY(3), .STEP_RESET_EN(1)
    ) dut (
        .clk(clk), .rst_l(rst_l),
        .game_start(game_start), .game_end(game_end), .user_input(user_input),
        .hard_drop(hard_drop), .soft_drop(soft_drop),
        .falling_row(falling_row), .falling_col(falling_col),
        .ghost_row(ghost_row), .ghost_col(ghost_col),
        .lines_pending(lines_pending), .clear_done(clear_done),
        .garbage_pending(garbage_pending), .garbage_done(garbage_done),
        .spawn_blocked(spawn_blocked),
        .new_tetromino(new_tetromino), .gravity_tick(gravity_tick),
        .falling_piece_lock(falling_piece_lock), .line_clear(line_clear),
        .load_garbage(load_garbage), .top_out(top_out),
        .lock_resets_used(lock_resets_used), .state_dbg(state_dbg)
    );

    // Input record bits.
    localparam logic [10:0] I_NONE  = 11'h000;
    localparam logic [10:0] I_START = 11'h001;
    localparam logic [10:0] I_END   = 11'h002;
    localparam logic [10:0] I_USER  = 11'h004;
    localparam logic [10:0] I_HARD  = 11'h008;
    localparam logic [10:0] I_SOFT  = 11'h010;
    localparam logic [10:0] I_GND   = 11'h020;
    localparam logic [10:0] I_LINES = 11'h040;
    localparam logic [10:0] I_CDONE = 11'h080;
    localparam logic [10:0] I_GARB  = 11'h100;
    localparam logic [10:0] I_GDONE = 11'h200;
    localparam logic [10:0] I_BLOCK = 11'h400;

    // Expected output flags {new, tick, lock, clear, garbage, top}.
    localparam logic [5:0] E_NONE = 6'h00;
    localparam logic [5:0] E_NEW  = 6'h20;
    localparam logic [5:0] E_TICK = 6'h10;
    localparam logic [5:0] E_LOCK = 6'h08;
    localparam logic [5:0] E_CLR  = 6'h04;
    localparam logic [5:0] E_GARB = 6'h02;
    localparam logic [5:0] E_TOP  = 6'h01;

    localparam logic [4:0] R0 = 5'd0;
    localparam logic [4:0] R2 = 5'd2;

    typedef struct {
        logic [10:0] in;
        logic [4:0]  row;
        logic [5:0]  flags;
        logic [1:0]  rc;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;
    logic [7:0] act_v;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic add(input logic [10:0] in, input logic [4:0] row,
                       input logic [5:0] flags, input logic [1:0] rc);
        vec_t v;
        v.in = in; v.row = row; v.flags = flags; v.rc = rc;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        game_start      = v.in[0];
        game_end        = v.in[1];
        user_input      = v.in[2];
        hard_drop       = v.in[3];
        soft_drop       = v.in[4];
        lines_pending   = v.in[6];
        clear_done      = v.in[7];
        garbage_pending = v.in[8];
        garbage_done    = v.in[9];
        spawn_blocked   = v.in[10];
        falling_row     = v.row;
        falling_col     = 5'd3;
        ghost_col       = 5'd3;
        ghost_row       = v.in[5] ? v.row : 5'd31;
    endtask

    // Pop the oldest expectation and compare it against the live outputs.
    task automatic check_next(input string name);
        act_v = {new_tetromino, gravity_tick, falling_piece_lock,
                 line_clear, load_garbage, top_out, lock_resets_used};
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected value queued, got %b", name, act_v);
        end else begin
            exp_v = exp_q.pop_front();
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s: got {new,tick,lock,clr,garb,top,rc}=%b expected %b",
                         name, act_v, exp_v);
            end
        end
    endtask

    initial begin
        vec_t zero_v;
        zero_v.in = I_NONE; zero_v.row = R0; zero_v.flags = E_NONE; zero_v.rc = 2'd0;
        rst_l = 1'b0;
        drive(zero_v);

        // Lock delay: grounded from the first falling cycle, lock 6 cycles after spawn.
        add(I_START, R0, E_NONE, 2'd0);
        add(I_NONE,  R0, E_NEW,  2'd0);
        repeat (5) add(I_GND, R0, E_NONE, 2'd0);
        add(I_NONE,  R0, E_LOCK, 2'd0);
        repeat (3) add(I_NONE, R0, E_NONE, 2'd0);
        add(I_NONE,  R0, E_NEW,  2'd0);
        // Move-reset budget of 2, then saturation; lock 5 grounded cycles after 2nd reset.
        add(I_GND,          R0, E_NONE, 2'd0);
        add(I_GND | I_USER, R0, E_NONE, 2'd0);
        add(I_GND,          R0, E_NONE, 2'd1);
        add(I_GND | I_USER, R0, E_NONE, 2'd1);
        add(I_GND,          R0, E_NONE, 2'd2);
        add(I_GND | I_USER, R0, E_NONE, 2'd2);
        add(I_GND,          R0, E_NONE, 2'd2);
        add(I_GND | I_USER, R0, E_NONE, 2'd2);
        add(I_GND,          R0, E_NONE, 2'd2);
        // Line clear for 3 cycles, garbage for 2, then 3 entry cycles.
        add(I_LINES | I_GARB,  R0, E_LOCK, 2'd2);
        add(I_GARB,            R0, E_CLR,  2'd2);
        add(I_GARB,            R0, E_CLR,  2'd2);
        add(I_GARB | I_CDONE,  R0, E_CLR,  2'd2);
        add(I_NONE,            R0, E_GARB, 2'd2);
        add(I_GDONE,           R0, E_GARB, 2'd2);
        repeat (3) add(I_NONE, R0, E_NONE, 2'd2);
        add(I_NONE,            R0, E_NEW,  2'd2);
        // Gravity 8, soft drop 2 pressed at ctr=5.
        add(I_NONE, R0, E_NONE, 2'd0);
        add(I_NONE, R0, E_NONE, 2'd0);
        add(I_SOFT, R0, E_NONE, 2'd0);
        add(I_SOFT, R0, E_NONE, 2'd0);
        add(I_SOFT, R0, E_TICK, 2'd0);
        add(I_SOFT, R0, E_NONE, 2'd0);
        add(I_SOFT, R0, E_TICK, 2'd0);
        add(I_NONE, R0, E_NONE, 2'd0);
        add(I_NONE, R0, E_TICK, 2'd0);
        repeat (7) add(I_NONE, R0, E_NONE, 2'd0);
        add(I_NONE, R0, E_TICK, 2'd0);
        // Hard drop with user_input while grounded: lock next, count unchanged.
        add(I_GND | I_USER,          R0, E_NONE, 2'd0);
        add(I_GND | I_USER | I_HARD, R0, E_NONE, 2'd1);
        add(I_NONE,                  R0, E_LOCK, 2'd1);
        repeat (3) add(I_NONE, R0, E_NONE, 2'd1);
        // Blocked spawn, top out held, abort, restart from TOP_OUT.
        add(I_BLOCK, R0, E_NEW,  2'd1);
        add(I_NONE,  R0, E_TOP,  2'd0);
        add(I_NONE,  R0, E_TOP,  2'd0);
        add(I_END,   R0, E_TOP,  2'd0);
        add(I_NONE,  R0, E_NONE, 2'd0);
        add(I_START, R0, E_NONE, 2'd0);
        add(I_BLOCK, R0, E_NEW,  2'd0);
        add(I_NONE,  R0, E_TOP,  2'd0);
        add(I_START, R0, E_TOP,  2'd0);
        add(I_NONE,  R0, E_NEW,  2'd0);
        // Step reset: reaching row 2 reloads the lock counter and clears the count.
        add(I_GND | I_USER, R0, E_NONE, 2'd0);
        add(I_GND,          R0, E_NONE, 2'd1);
        add(I_GND,          R2, E_NONE, 2'd1);
        repeat (5) add(I_GND, R2, E_NONE, 2'd0);
        add(I_NONE,  R0, E_LOCK, 2'd0);
        add(I_END,   R0, E_NONE, 2'd0);
        add(I_START, R0, E_NONE, 2'd0);
        add(I_NONE,  R0, E_NEW,  2'd0);
        add(I_HARD,  R0, E_NONE, 2'd0);
        add(I_LINES, R0, E_LOCK, 2'd0);
        add(I_NONE,  R0, E_CLR,  2'd0);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_q.push_back(8'h00);
        check_next("reset_state");
        @(posedge clk);
        #1 rst_l = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            exp_q.push_back({vecs[i].flags, vecs[i].rc});
            @(negedge clk);
            check_next($sformatf("vec%0d", i));
            @(posedge clk);
            #1;
        end

        // Still in LINE_CLEAR; async reset must drop the request at once.
        drive(zero_v);
        exp_q.push_back({E_CLR, 2'd0});
        #1 check_next("clear_before_reset");
        rst_l = 1'b0;
        exp_q.push_back(8'h00);
        #1 check_next("async_reset_mid_clear");
        @(posedge clk);
        #1 rst_l = 1'b1;
        exp_q.push_back(8'h00);
        @(negedge clk);
        check_next("idle_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
